bus_fabric_6502: RTL and testbench

//  Parametrised address decoder, read-data mux and RDY/wait-state generator between the 6502

---
 rtl/bus_fabric_6502.sv | 147 ++++++++++++++
 tb/tb_bus_fabric_6502.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric_6502.sv
// Address decoder, read-data mux and RDY/wait-state generator between the 6502 core and
// NSLV on-chip slaves. Table-driven decode (lowest index wins), per-slave programmable wait
// states, an all-ones default slave for unmapped addresses and a stall timeout with error
// capture.
module bus_fabric_6502 #(
   parameter int unsigned         NSLV     = 10,
   parameter int unsigned         AW       = 16,
   parameter int unsigned         DW       = 8,
   parameter int unsigned         WS_W     = 2,
   parameter int unsigned         TMO      = 255,
   parameter logic [NSLV*AW-1:0]  SLV_BASE = {16'h9000, 16'h8000, 16'h7000, 16'h6000,
                                              16'h5000, 16'h4000, 16'h3000, 16'h2000,
                                              16'h1000, 16'h0000},
   parameter logic [NSLV*AW-1:0]  SLV_MASK = {NSLV{16'hF000}}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [AW-1:0]        cpu_ab,
   input  logic                 cpu_we,
   output logic [DW-1:0]        cpu_di,
   output logic                 cpu_rdy,
   output logic [NSLV-1:0]      slv_sel,
   output logic                 slv_we,
   input  logic [NSLV*DW-1:0]   slv_do,
   input  logic [NSLV-1:0]      slv_rdy,
   input  logic [NSLV*WS_W-1:0] ws_cfg,
   output logic                 bus_err,
   output logic [AW-1:0]        err_addr
);

   localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int unsigned TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

   localparam logic [0:0] StAcc  = 1'b0;
   localparam logic [0:0] StWait = 1'b1;

   logic [0:0]      state_q, state_d;
   logic [WS_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [NSLV:0]   dsel_q, dsel_d;
   logic            bus_err_q, bus_err_d;
   logic [AW-1:0]   err_addr_q, err_addr_d;

   logic            hit;
   logic [IW-1:0]   idx;
   logic            sel_rdy;
   logic [WS_W-1:0] sel_ws;
   logic            tmo_fire;

   // Address decode: walk downwards so the lowest matching index is the one left standing
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = int'(NSLV) - 1; i >= 0; i--) begin
         if ((cpu_ab & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

   // Slave-side selects and the decoded slave's ready / wait-state field
   always_comb begin
      slv_sel = '0;
      if (hit) slv_sel[idx] = 1'b1;
      slv_we  = cpu_we & hit;
      // Default slave is always ready and never inserts wait states
      sel_rdy = hit ? slv_rdy[idx] : 1'b1;
      sel_ws  = hit ? ws_cfg[idx*WS_W +: WS_W] : '0;
   end

   // Access FSM: ACC is the first cycle of every access, WAIT covers the stall
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      cpu_rdy  = 1'b0;
      tmo_fire = 1'b0;
      unique case (state_q)
         StAcc: begin
            // tmo_q tracks the cycle index within the access; the first WAIT cycle is 1
            tmo_d = TW'(1);
            if (sel_ws == '0) begin
               cpu_rdy = sel_rdy;
               if (!sel_rdy) begin
                  state_d = StWait;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d   = sel_ws - WS_W'(1);
               state_d = StWait;
            end
         end
         default: begin
            cpu_rdy = (cnt_q == '0) & sel_rdy;
            if (cnt_q != '0) cnt_d = cnt_q - WS_W'(1);
            // A ready slave in the timeout cycle completes normally
            if (!cpu_rdy && (TMO != 0) && (tmo_q == TW'(TMO - 1))) begin
               tmo_fire = 1'b1;
               cpu_rdy  = 1'b1;
            end
            if (TMO != 0) tmo_d = tmo_q + TW'(1);
            if (cpu_rdy) state_d = StAcc;
         end
      endcase
   end

   // Data-phase select and error capture
   always_comb begin
      dsel_d = dsel_q;
      if (cpu_rdy) dsel_d = tmo_fire ? {1'b1, {NSLV{1'b0}}} : {~hit, slv_sel};
      bus_err_d  = ((state_q == StAcc) && !hit) || tmo_fire;
      err_addr_d = bus_err_d ? cpu_ab : err_addr_q;
   end

   // Read-data mux driven from the registered select; top bit is the all-ones default
   always_comb begin
      cpu_di = '0;
      for (int i = 0; i < int'(NSLV); i++) begin
         if (dsel_q[i]) cpu_di = cpu_di | slv_do[i*DW +: DW];
      end
      if (dsel_q[NSLV]) cpu_di = {DW{1'b1}};
   end

   // State registers, synchronous reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StAcc;
         cnt_q      <= '0;
         tmo_q      <= '0;
         dsel_q     <= {1'b1, {NSLV{1'b0}}};
         bus_err_q  <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         dsel_q     <= dsel_d;
         bus_err_q  <= bus_err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus_err  = bus_err_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_fabric_6502.sv
// Bench for bus_fabric_6502: directed and randomized accesses checked against a
// per-access model (table decode, stall = max(wait states, slave delay), timeout cap).
`timescale 1ns/1ps
module tb_bus_fabric_6502;

   localparam int unsigned NSLV = 10;
   localparam int unsigned TMO  = 255;
   localparam logic [NSLV*16-1:0] TB_BASE = {16'h9000, 16'h8000, 16'h7000, 16'h6000,
                                             16'h5000, 16'h4000, 16'h3000, 16'h2000,
                                             16'h1000, 16'h0000};
   localparam logic [NSLV*16-1:0] TB_MASK = {NSLV{16'hF000}};

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [15:0]     cpu_ab = '0;
   logic            cpu_we = 1'b0;
   logic [7:0]      cpu_di;
   logic            cpu_rdy;
   logic [NSLV-1:0] slv_sel;
   logic            slv_we;
   logic [NSLV*8-1:0] slv_do = '0;
   logic [NSLV-1:0] slv_rdy = '1;
   logic [NSLV*2-1:0] ws_cfg = '0;
   logic            bus_err;
   logic [15:0]     err_addr;

   // Second instance with overlapping regions: slave 0 = 0000-7FFF, slave 1 = 0000-FFFF
   logic [7:0]      ov_cpu_di;
   logic            ov_cpu_rdy;
   logic [1:0]      ov_slv_sel;
   logic            ov_slv_we;
   logic            ov_bus_err;
   logic [15:0]     ov_err_addr;

   int n_vec = 0;
   int n_err = 0;

   // Model state carried from one access into the next one's first cycle
   int          pend_idx = -1;
   logic        pend_err = 1'b0;
   logic [15:0] err_addr_m = '0;

   always #5 clk = ~clk;

   bus_fabric_6502 #(
      .NSLV(NSLV), .AW(16), .DW(8), .WS_W(2), .TMO(TMO),
      .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK)
   ) dut (
      .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_di(cpu_di),
      .cpu_rdy(cpu_rdy), .slv_sel(slv_sel), .slv_we(slv_we), .slv_do(slv_do),
      .slv_rdy(slv_rdy), .ws_cfg(ws_cfg), .bus_err(bus_err), .err_addr(err_addr)
   );

   bus_fabric_6502 #(
      .NSLV(2), .AW(16), .DW(8), .WS_W(2), .TMO(TMO),
      .SLV_BASE({16'h0000, 16'h0000}), .SLV_MASK({16'h0000, 16'h8000})
   ) u_ov (
      .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_di(ov_cpu_di),
      .cpu_rdy(ov_cpu_rdy), .slv_sel(ov_slv_sel), .slv_we(ov_slv_we), .slv_do(16'h5AA5),
      .slv_rdy(2'b11), .ws_cfg(4'h0), .bus_err(ov_bus_err), .err_addr(ov_err_addr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int decode(input logic [15:0] a);
      logic [NSLV*16-1:0] b;
      logic [NSLV*16-1:0] m;
      b = TB_BASE;
      m = TB_MASK;
      for (int i = 0; i < int'(NSLV); i++) begin
         if ((a & m[i*16 +: 16]) == b[i*16 +: 16]) return i;
      end
      return -1;
   endfunction

   // One CPU access; d = cycle index at which the target slave raises slv_rdy
   task automatic do_access(input logic [15:0] addr, input logic we, input int d,
                            input bit fixed_data);
      int          idx, w, rel;
      bit          tmo;
      logic [7:0]  exp_di;
      logic [NSLV-1:0] exp_sel;
      idx = decode(addr);
      cpu_ab = addr;
      cpu_we = we;
      for (int i = 0; i < int'(NSLV); i++)
         slv_do[i*8 +: 8] = fixed_data ? 8'(8'hA0 + i) : 8'($urandom);
      w   = (idx < 0) ? 0 : int'(ws_cfg[idx*2 +: 2]);
      rel = (idx < 0) ? 0 : ((w > d) ? w : d);
      tmo = (rel > int'(TMO) - 1);
      if (tmo) rel = int'(TMO) - 1;
      exp_sel = '0;
      if (idx >= 0) exp_sel[idx] = 1'b1;
      for (int k = 0; k <= rel; k++) begin
         slv_rdy = NSLV'($urandom);
         if (idx >= 0) slv_rdy[idx] = (k >= d);
         if (k > 0) ws_cfg = 20'($urandom);
         @(negedge clk);
         if (k == 0) begin
            exp_di = (pend_idx < 0) ? 8'hFF : slv_do[pend_idx*8 +: 8];
            chk("cpu_di", 32'(cpu_di), 32'(exp_di));
            chk("bus_err", 32'(bus_err), 32'(pend_err));
            chk("err_addr", 32'(err_addr), 32'(err_addr_m));
         end else begin
            chk("bus_err_wait", 32'(bus_err), 32'(0));
         end
         chk("cpu_rdy", 32'(cpu_rdy), 32'(k == rel));
         chk("slv_sel", 32'(slv_sel), 32'(exp_sel));
         chk("slv_we", 32'(slv_we), 32'(we && (idx >= 0)));
         @(posedge clk);
         #1;
      end
      pend_err = (idx < 0) || tmo;
      pend_idx = pend_err ? -1 : idx;
      if (pend_err) err_addr_m = addr;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // No wait states: each slave returns its own data in the cycle after ready
      ws_cfg = '0;
      for (int i = 0; i < int'(NSLV); i++) do_access(16'(i * 16'h1000 + 16'h0042), 1'b0, 0, 1'b1);

      // Three wait states on slave 3
      ws_cfg = '0;
      ws_cfg[3*2 +: 2] = 2'd3;
      do_access(16'h3010, 1'b0, 0, 1'b0);

      // Unmapped address: default slave, error pulse and capture
      do_access(16'hF600, 1'b0, 0, 1'b0);
      do_access(16'h0001, 1'b0, 0, 1'b0);

      // Slave 2 never ready: timeout; then ready exactly in the timeout cycle
      ws_cfg = '0;
      do_access(16'h2000, 1'b0, 100000, 1'b0);
      ws_cfg = '0;
      do_access(16'h2004, 1'b0, int'(TMO) - 1, 1'b0);
      ws_cfg = '0;
      do_access(16'h2008, 1'b0, 0, 1'b0);

      // Overlapping regions on the second instance; lowest index wins
      ws_cfg = '0;
      do_access(16'h1234, 1'b1, 0, 1'b0);
      #1;
      chk("ov_sel_1234", 32'(ov_slv_sel), 32'(2'b01));
      chk("ov_we_1234", 32'(ov_slv_we), 32'(1));
      ws_cfg = '0;
      do_access(16'h9234, 1'b1, 0, 1'b0);
      #1;
      chk("ov_sel_9234", 32'(ov_slv_sel), 32'(2'b10));
      chk("ov_we_9234", 32'(ov_slv_we), 32'(1));

      // Randomized accesses
      for (int n = 0; n < 150; n++) begin
         int d;
         d = $urandom_range(0, 5);
         if ($urandom_range(0, 24) == 0) d = 300;
         do_access(16'($urandom), 1'($urandom), d, 1'b0);
      end

      // Reset in the middle of a 3-cycle wait
      do_access(16'hF600, 1'b0, 0, 1'b0);
      ws_cfg = '0;
      ws_cfg[3*2 +: 2] = 2'd3;
      cpu_ab  = 16'h3000;
      cpu_we  = 1'b0;
      slv_rdy = '1;
      @(negedge clk);
      chk("rst_wait_c0", 32'(cpu_rdy), 32'(0));
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_wait_c1", 32'(cpu_rdy), 32'(0));
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      pend_idx   = -1;
      pend_err   = 1'b0;
      err_addr_m = '0;
      ws_cfg = '0;
      do_access(16'h3000, 1'b0, 0, 1'b0);
      do_access(16'h4000, 1'b0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
